// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/WB to scoreboard signal bundle
interface reg_scoreboard_if #(
  parameter int REG_COUNT = 16
);
  localparam int IDX_W = $clog2(REG_COUNT);

  logic                 id_valid;
  logic [IDX_W-1:0]     src1;
  logic [IDX_W-1:0]     src2;
  logic                 two_src;
  logic                 id_wb_en;
  logic [IDX_W-1:0]     id_dest;
  logic                 wb_en;
  logic [IDX_W-1:0]     wb_dest;
  logic                 stall;
  logic                 issue;
  logic [REG_COUNT-1:0] pending;
  logic                 err;

  modport master (
    output id_valid, src1, src2, two_src, id_wb_en, id_dest, wb_en, wb_dest,
    input  stall, issue, pending, err
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_wb_en, id_dest, wb_en, wb_dest,
    output stall, issue, pending, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write counters driving the ID stall
module reg_scoreboard #(
  parameter int REG_COUNT = 16,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave sb
);
  localparam int             IDX_W   = $clog2(REG_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     cnt_q [REG_COUNT];
  logic [CNT_W-1:0]     cnt_d [REG_COUNT];
  logic                 err_q;
  logic                 err_d;

  logic                 done_s1;
  logic                 done_s2;
  logic                 done_dst;
  logic [CNT_W-1:0]     left_s1;
  logic [CNT_W-1:0]     left_s2;
  logic                 busy_s1;
  logic                 busy_s2;
  logic                 full;
  logic                 stall;
  logic                 issue;
  logic                 inc;
  logic                 dec;
  logic [REG_COUNT-1:0] inc_vec;
  logic [REG_COUNT-1:0] dec_vec;
  logic [REG_COUNT-1:0] pending;

  // A write completing this cycle is already visible to readers when bypassing
  assign done_s1  = (WB_BYPASS != 0) && sb.wb_en && (sb.wb_dest == sb.src1);
  assign done_s2  = (WB_BYPASS != 0) && sb.wb_en && (sb.wb_dest == sb.src2);
  assign done_dst = (WB_BYPASS != 0) && sb.wb_en && (sb.wb_dest == sb.id_dest);

  assign left_s1  = cnt_q[sb.src1] - CNT_W'(done_s1);
  assign left_s2  = cnt_q[sb.src2] - CNT_W'(done_s2);
  assign busy_s1  = (left_s1 != '0);
  assign busy_s2  = (left_s2 != '0);
  assign full     = sb.id_wb_en && (cnt_q[sb.id_dest] == CNT_MAX) && !done_dst;

  assign stall    = sb.id_valid && (busy_s1 || (sb.two_src && busy_s2) || full);
  assign issue    = sb.id_valid && !stall;
  assign inc      = issue && sb.id_wb_en;
  assign dec      = sb.wb_en && (cnt_q[sb.wb_dest] != '0);

  assign inc_vec  = inc ? (REG_COUNT'(1) << sb.id_dest) : '0;
  assign dec_vec  = dec ? (REG_COUNT'(1) << sb.wb_dest) : '0;

  // Matching inc and dec on one register cancel; full blocks inc at max, dec needs nonzero
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r] + CNT_W'(inc_vec[r]) - CNT_W'(dec_vec[r]);
    end
    err_d = err_q || (sb.wb_en && (cnt_q[sb.wb_dest] == '0));
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign sb.stall   = stall;
  assign sb.issue   = issue;
  assign sb.pending = pending;
  assign sb.err     = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed and random checks of reg_scoreboard against a counter model
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.REG_COUNT(16)) sb_if ();

  reg_scoreboard #(.REG_COUNT(16), .CNT_W(2), .WB_BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic        issue;
    logic [15:0] pending;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt [16];
  bit   merr;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit busy_m(input int x, input bit dn);
    return ((mcnt[x] - int'(dn)) & 3) != 0;
  endfunction

  task automatic cyc(input string tag, input bit r, input bit idv, input int s1, input int s2,
                     input bit two, input bit idwb, input int dst, input bit wbe, input int wbd);
    exp_t e;
    exp_t o;
    bit   st;
    bit   iss;
    bit   full;
    logic [15:0] pend;
    @(negedge clk);
    rst            = r;
    sb_if.id_valid = idv;
    sb_if.src1     = 4'(s1);
    sb_if.src2     = 4'(s2);
    sb_if.two_src  = two;
    sb_if.id_wb_en = idwb;
    sb_if.id_dest  = 4'(dst);
    sb_if.wb_en    = wbe;
    sb_if.wb_dest  = 4'(wbd);

    full = idwb && (mcnt[dst] == 3) && !(wbe && wbd == dst);
    st   = idv && (busy_m(s1, wbe && wbd == s1) || (two && busy_m(s2, wbe && wbd == s2)) || full);
    iss  = idv && !st;
    for (int i = 0; i < 16; i++) pend[i] = (mcnt[i] != 0);
    e.tag = tag; e.stall = st; e.issue = iss; e.pending = pend; e.err = merr;
    exp_q.push_back(e);

    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      check({o.tag, ".stall"},   32'(sb_if.stall),   32'(o.stall));
      check({o.tag, ".issue"},   32'(sb_if.issue),   32'(o.issue));
      check({o.tag, ".pending"}, 32'(sb_if.pending), 32'(o.pending));
      check({o.tag, ".err"},     32'(sb_if.err),     32'(o.err));
    end

    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
      merr = 1'b0;
    end else begin
      if (wbe && mcnt[wbd] == 0) merr = 1'b1;
      if (wbe && mcnt[wbd] != 0) mcnt[wbd] = mcnt[wbd] - 1;
      if (iss && idwb) mcnt[dst] = mcnt[dst] + 1;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    merr = 1'b0;
    rst = 1'b1;
    sb_if.id_valid = 1'b0; sb_if.src1 = '0; sb_if.src2 = '0; sb_if.two_src = 1'b0;
    sb_if.id_wb_en = 1'b0; sb_if.id_dest = '0; sb_if.wb_en = 1'b0; sb_if.wb_dest = '0;
    @(posedge clk);

    // reset with a valid instruction on src1=3
    cyc("rst", 1, 1, 3, 0, 0, 0, 0, 0, 0);

    // single write then RAW hazard cleared by bypass
    cyc("iss2",   0, 1, 0, 0, 0, 1, 2, 0, 0);
    cyc("haz2",   0, 1, 2, 0, 0, 0, 0, 0, 0);
    cyc("byp2",   0, 1, 2, 0, 0, 0, 0, 1, 2);
    idle("clr2");

    // src2 only matters when two_src is set
    cyc("iss5",   0, 1, 0, 0, 0, 1, 5, 0, 0);
    cyc("s2off",  0, 1, 0, 5, 0, 0, 0, 0, 0);
    cyc("s2on",   0, 1, 0, 5, 1, 0, 0, 0, 0);
    cyc("wb5",    0, 0, 0, 0, 0, 0, 0, 1, 5);

    // two writes outstanding on r7
    cyc("iss7a",  0, 1, 0, 0, 0, 1, 7, 0, 0);
    cyc("iss7b",  0, 1, 0, 0, 0, 1, 7, 0, 0);
    cyc("wb7a",   0, 1, 7, 0, 0, 0, 0, 1, 7);
    cyc("haz7",   0, 1, 7, 0, 0, 0, 0, 0, 0);
    cyc("wb7b",   0, 1, 7, 0, 0, 0, 0, 1, 7);
    idle("clr7");

    // simultaneous inc and dec on r4
    cyc("iss4",   0, 1, 0, 0, 0, 1, 4, 0, 0);
    cyc("sim4",   0, 1, 0, 0, 0, 1, 4, 1, 4);
    cyc("hold4",  0, 1, 4, 0, 0, 0, 0, 0, 0);
    cyc("wb4",    0, 0, 0, 0, 0, 0, 0, 1, 4);

    // saturate r9, then full stall, then full relieved by completing write
    cyc("iss9a",  0, 1, 0, 0, 0, 1, 9, 0, 0);
    cyc("iss9b",  0, 1, 0, 0, 0, 1, 9, 0, 0);
    cyc("iss9c",  0, 1, 0, 0, 0, 1, 9, 0, 0);
    cyc("full9",  0, 1, 0, 0, 0, 1, 9, 0, 0);
    cyc("swap9",  0, 1, 0, 0, 0, 1, 9, 1, 9);
    cyc("wb9a",   0, 0, 0, 0, 0, 0, 0, 1, 9);
    cyc("wb9b",   0, 0, 0, 0, 0, 0, 0, 1, 9);
    cyc("wb9c",   0, 1, 9, 0, 0, 0, 0, 1, 9);
    idle("clr9");

    // PC register tracked like the rest
    cyc("iss15",  0, 1, 0, 0, 0, 1, 15, 0, 0);
    cyc("haz15",  0, 1, 15, 0, 0, 0, 0, 0, 0);
    cyc("wb15",   0, 0, 0, 0, 0, 0, 0, 1, 15);

    // underflow sets sticky err
    cyc("uf11",   0, 0, 0, 0, 0, 0, 0, 1, 11);
    idle("err1");
    idle("err2");

    // reset mid-flight discards counts and err
    cyc("iss1a",  0, 1, 0, 0, 0, 1, 1, 0, 0);
    cyc("iss1b",  0, 1, 0, 0, 0, 1, 1, 0, 0);
    cyc("rstmid", 1, 1, 0, 0, 0, 1, 1, 1, 1);
    cyc("post",   0, 1, 1, 0, 0, 0, 0, 0, 0);

    // random traffic, mostly legal write-backs
    for (int n = 0; n < 400; n++) begin
      int  wbd;
      bit  wbe;
      wbd = $urandom_range(0, 15);
      for (int t = 0; t < 16 && mcnt[wbd] == 0; t++) wbd = $urandom_range(0, 15);
      wbe = (mcnt[wbd] != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      cyc("rnd", ($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1) != 0,
          $urandom_range(0, 1) != 0, $urandom_range(0, 15), wbe, wbd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
